// File: rtl/player_ship_pkg.sv
// ----------------------------------------------------------------------------
// player_ship_pkg
// Shared playfield constants, FSM state types and the box-intersection helper
// used by the player ship and by the enemy collision logic.
// No ports (package).
// ----------------------------------------------------------------------------
package player_ship_pkg;

    // Playfield limits in pixels
    localparam logic [9:0] SCREEN_LEFT  = 10'd9;
    localparam logic [9:0] SCREEN_RIGHT = 10'd629;
    localparam logic [9:0] SCREEN_TOP   = 10'd10;
    localparam logic [9:0] SHIP_TOP     = 10'd440;
    localparam logic [9:0] SHIP_HEIGHT  = 10'd20;

    // Player bullet geometry relative to the ship / itself
    localparam logic [9:0] BULLET_X_OFFSET = 10'd19;
    localparam logic [9:0] BULLET_WIDTH    = 10'd2;
    localparam logic [9:0] BULLET_HEIGHT   = 10'd10;

    typedef enum logic [1:0] {
        ALIVE,
        INVULN,
        DEAD
    } ship_state_e;

    typedef enum logic {
        READY,
        FLYING
    } bullet_state_e;

    // Two boxes intersect when they overlap on both axes; edges that merely
    // touch still count as a collision.
    function automatic logic box_overlap(
        input logic [9:0] l1, input logic [9:0] r1,
        input logic [9:0] t1, input logic [9:0] b1,
        input logic [9:0] l2, input logic [9:0] r2,
        input logic [9:0] t2, input logic [9:0] b2
    );
        return (l1 <= r2) && (l2 <= r1) && (t1 <= b2) && (t2 <= b1);
    endfunction

endpackage

// File: rtl/player_ship_if.sv
// ----------------------------------------------------------------------------
// player_ship_if
// Bundles the frame tick, player buttons, enemy-side status and all player
// ship / bullet outputs into one interface.
//   slave  : the player_ship block (consumes inputs, drives outputs)
//   master : whoever drives the game inputs (top level or testbench)
// ----------------------------------------------------------------------------
interface player_ship_if;

    logic       frame_i;
    logic       left_btn_i;
    logic       right_btn_i;
    logic       fire_btn_i;
    logic       enemy_hit_i;
    logic       landed_i;
    logic       ebullet_active_i;
    logic [9:0] ebullet_left_i;
    logic [9:0] ebullet_right_i;
    logic [9:0] ebullet_top_i;
    logic [9:0] ebullet_bot_i;

    logic [9:0] left_pos_o;
    logic [9:0] right_pos_o;
    logic [9:0] top_pos_o;
    logic [9:0] bot_pos_o;
    logic [9:0] pbullet_left_o;
    logic [9:0] pbullet_right_o;
    logic [9:0] pbullet_top_o;
    logic [9:0] pbullet_bot_o;
    logic       pbullet_active_o;
    logic       hit_player_o;
    logic [1:0] lives_o;
    logic       player_dead_o;
    logic [3:0] player_red_o;
    logic [3:0] player_green_o;
    logic [3:0] player_blue_o;

    modport slave (
        input  frame_i, left_btn_i, right_btn_i, fire_btn_i,
        input  enemy_hit_i, landed_i, ebullet_active_i,
        input  ebullet_left_i, ebullet_right_i, ebullet_top_i, ebullet_bot_i,
        output left_pos_o, right_pos_o, top_pos_o, bot_pos_o,
        output pbullet_left_o, pbullet_right_o, pbullet_top_o, pbullet_bot_o,
        output pbullet_active_o, hit_player_o, lives_o, player_dead_o,
        output player_red_o, player_green_o, player_blue_o
    );

    modport master (
        output frame_i, left_btn_i, right_btn_i, fire_btn_i,
        output enemy_hit_i, landed_i, ebullet_active_i,
        output ebullet_left_i, ebullet_right_i, ebullet_top_i, ebullet_bot_i,
        input  left_pos_o, right_pos_o, top_pos_o, bot_pos_o,
        input  pbullet_left_o, pbullet_right_o, pbullet_top_o, pbullet_bot_o,
        input  pbullet_active_o, hit_player_o, lives_o, player_dead_o,
        input  player_red_o, player_green_o, player_blue_o
    );

endinterface

// File: rtl/player_ship_bullet.sv
// ----------------------------------------------------------------------------
// player_ship_bullet
// The single player bullet: launches above the ship, climbs one step per
// frame, and retires on an enemy hit or near the top of the screen.
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   i_launch                 start a flight this cycle (only honoured in READY)
//   i_frame                  one-cycle frame tick
//   i_enemyHit               bullet struck an enemy, retire now
//   i_kill                   force READY (player is dead)
//   i_shipLeft, i_shipTop    ship box corner used as launch origin
//   o_left/right/top/bot     bullet box, all zero while READY
//   o_active                 bullet in flight
// ----------------------------------------------------------------------------
module player_ship_bullet
    import player_ship_pkg::*;
#(
    parameter logic [9:0] bullet_step_p = 10'd10
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       i_launch,
    input  logic       i_frame,
    input  logic       i_enemyHit,
    input  logic       i_kill,
    input  logic [9:0] i_shipLeft,
    input  logic [9:0] i_shipTop,
    output logic [9:0] o_left,
    output logic [9:0] o_right,
    output logic [9:0] o_top,
    output logic [9:0] o_bot,
    output logic       o_active
);

    bullet_state_e r_state;
    logic [9:0]    r_left;
    logic [9:0]    r_right;
    logic [9:0]    r_top;
    logic [9:0]    r_bot;

    // Bullet FSM and box registers. A hit outranks a frame step in the same
    // cycle. The top-of-screen retire test runs before the step, so the box
    // can never be moved past the top and wrap.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= READY;
            r_left  <= '0;
            r_right <= '0;
            r_top   <= '0;
            r_bot   <= '0;
        end else if (i_kill) begin
            r_state <= READY;
            r_left  <= '0;
            r_right <= '0;
            r_top   <= '0;
            r_bot   <= '0;
        end else begin
            case (r_state)
                READY: begin
                    if (i_launch) begin
                        r_state <= FLYING;
                        r_left  <= i_shipLeft + BULLET_X_OFFSET;
                        r_right <= i_shipLeft + BULLET_X_OFFSET + BULLET_WIDTH;
                        r_bot   <= i_shipTop - 10'd1;
                        r_top   <= i_shipTop - 10'd1 - BULLET_HEIGHT;
                    end
                end
                FLYING: begin
                    if (i_enemyHit || (i_frame && (r_top < SCREEN_TOP + bullet_step_p))) begin
                        r_state <= READY;
                        r_left  <= '0;
                        r_right <= '0;
                        r_top   <= '0;
                        r_bot   <= '0;
                    end else if (i_frame) begin
                        r_top <= r_top - bullet_step_p;
                        r_bot <= r_bot - bullet_step_p;
                    end
                end
            endcase
        end
    end

    assign o_left   = r_left;
    assign o_right  = r_right;
    assign o_top    = r_top;
    assign o_bot    = r_bot;
    assign o_active = (r_state == FLYING);

endmodule

// File: rtl/player_ship.sv
// ----------------------------------------------------------------------------
// player_ship
// Player ship along the bottom row: movement, firing of the single player
// bullet, enemy-bullet collision, lives, invulnerability blink and game over.
// Ports:
//   clk_i      system clock
//   reset_ni   asynchronous active-low reset
//   bus        player_ship_if.slave carrying frame tick, buttons, enemy
//              status/bullet box in and ship/bullet boxes, lives, hit,
//              dead flag and colour out
// ----------------------------------------------------------------------------
module player_ship
    import player_ship_pkg::*;
#(
    parameter logic [11:0] color_p         = 12'h0F0,
    parameter logic [9:0]  left_start_p    = 10'd300,
    parameter logic [9:0]  ship_width_p    = 10'd40,
    parameter logic [9:0]  move_step_p     = 10'd5,
    parameter logic [9:0]  bullet_step_p   = 10'd10,
    parameter logic [1:0]  lives_p         = 2'd3,
    parameter logic [7:0]  invuln_frames_p = 8'd120
) (
    input logic         clk_i,
    input logic         reset_ni,
    player_ship_if.slave bus
);

    ship_state_e r_shipState;
    logic [9:0]  r_shipLeft;
    logic [7:0]  r_invulnCnt;
    logic [1:0]  r_lives;
    logic        r_hitPlayer;
    logic        r_playerDead;
    logic        r_firePrev;
    logic        r_fireLatch;

    logic [9:0]  w_shipRight;
    logic [9:0]  w_shipBot;
    logic        w_overlap;
    logic        w_launch;
    logic        w_bulletActive;
    logic        w_isDead;
    logic        w_blank;

    assign w_shipRight = r_shipLeft + ship_width_p;
    assign w_shipBot   = SHIP_TOP + SHIP_HEIGHT;
    assign w_isDead    = (r_shipState == DEAD);
    assign w_overlap   = bus.ebullet_active_i &&
                         box_overlap(r_shipLeft, w_shipRight, SHIP_TOP, w_shipBot,
                                     bus.ebullet_left_i, bus.ebullet_right_i,
                                     bus.ebullet_top_i, bus.ebullet_bot_i);
    assign w_launch    = bus.frame_i && r_fireLatch && !w_bulletActive && !w_isDead;

    // Horizontal movement, one step per frame. Clamping is done before the
    // step is applied so the ship lands exactly on the screen edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_shipLeft <= left_start_p;
        end else if (bus.frame_i && !w_isDead) begin
            if (bus.left_btn_i && !bus.right_btn_i) begin
                r_shipLeft <= (r_shipLeft >= SCREEN_LEFT + move_step_p) ?
                              r_shipLeft - move_step_p : SCREEN_LEFT;
            end else if (bus.right_btn_i && !bus.left_btn_i) begin
                r_shipLeft <= (r_shipLeft + move_step_p + ship_width_p <= SCREEN_RIGHT) ?
                              r_shipLeft + move_step_p : SCREEN_RIGHT - ship_width_p;
            end
        end
    end

    // Fire request latch: only a fresh press counts, and a press arriving
    // while the bullet is already flying (or after death) is thrown away
    // rather than queued for the next launch.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_firePrev  <= 1'b0;
            r_fireLatch <= 1'b0;
        end else begin
            r_firePrev <= bus.fire_btn_i;
            if (w_isDead || w_bulletActive || w_launch) begin
                r_fireLatch <= 1'b0;
            end else if (bus.fire_btn_i && !r_firePrev) begin
                r_fireLatch <= 1'b1;
            end
        end
    end

    // Ship life-cycle FSM. A landed enemy ends the game from any state.
    // The invulnerability countdown ticks on frames and hands control back
    // to ALIVE on the frame it would reach zero.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_shipState  <= ALIVE;
            r_invulnCnt  <= '0;
            r_lives      <= lives_p;
            r_hitPlayer  <= 1'b0;
            r_playerDead <= 1'b0;
        end else begin
            r_hitPlayer <= 1'b0;
            if (bus.landed_i) begin
                r_shipState  <= DEAD;
                r_lives      <= '0;
                r_playerDead <= 1'b1;
            end else begin
                case (r_shipState)
                    ALIVE: begin
                        if (bus.frame_i && w_overlap) begin
                            r_hitPlayer <= 1'b1;
                            if (r_lives <= 2'd1) begin
                                r_lives      <= '0;
                                r_shipState  <= DEAD;
                                r_playerDead <= 1'b1;
                            end else begin
                                r_lives     <= r_lives - 2'd1;
                                r_shipState <= INVULN;
                                r_invulnCnt <= invuln_frames_p;
                            end
                        end
                    end
                    INVULN: begin
                        if (bus.frame_i) begin
                            if (r_invulnCnt <= 8'd1) begin
                                r_invulnCnt <= '0;
                                r_shipState <= ALIVE;
                            end else begin
                                r_invulnCnt <= r_invulnCnt - 8'd1;
                            end
                        end
                    end
                    DEAD: begin
                        r_playerDead <= 1'b1;
                    end
                    default: begin
                        r_shipState  <= DEAD;
                        r_playerDead <= 1'b1;
                    end
                endcase
            end
        end
    end

    player_ship_bullet #(
        .bullet_step_p (bullet_step_p)
    ) u_bullet (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .i_launch   (w_launch),
        .i_frame    (bus.frame_i),
        .i_enemyHit (bus.enemy_hit_i),
        .i_kill     (w_isDead),
        .i_shipLeft (r_shipLeft),
        .i_shipTop  (SHIP_TOP),
        .o_left     (bus.pbullet_left_o),
        .o_right    (bus.pbullet_right_o),
        .o_top      (bus.pbullet_top_o),
        .o_bot      (bus.pbullet_bot_o),
        .o_active   (w_bulletActive)
    );

    // Blink by blanking the ship every other 8-frame window of invulnerability
    assign w_blank = (r_shipState == INVULN) && r_invulnCnt[3];

    assign bus.left_pos_o       = r_shipLeft;
    assign bus.right_pos_o      = w_shipRight;
    assign bus.top_pos_o        = SHIP_TOP;
    assign bus.bot_pos_o        = w_shipBot;
    assign bus.pbullet_active_o = w_bulletActive;
    assign bus.hit_player_o     = r_hitPlayer;
    assign bus.lives_o          = r_lives;
    assign bus.player_dead_o    = r_playerDead;
    assign bus.player_red_o     = w_blank ? 4'h0 : color_p[11:8];
    assign bus.player_green_o   = w_blank ? 4'h0 : color_p[7:4];
    assign bus.player_blue_o    = w_blank ? 4'h0 : color_p[3:0];

endmodule

// File: tb/tb_player_ship.sv
// ----------------------------------------------------------------------------
// tb_player_ship
// Directed bench for player_ship: movement clamps, bullet launch/flight/
// retire, collision with invulnerability window, lives and game over.
// ----------------------------------------------------------------------------
module tb_player_ship;

    logic clk_i = 1'b0;
    logic reset_ni;
    int   compared = 0;
    int   mismatched = 0;
    int   hitCount = 0;
    int   launchCount = 0;
    logic prevActive = 1'b0;
    int   base;
    int   maxRight;

    player_ship_if bus();

    player_ship dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    // 100 MHz clock
    always #5 clk_i = ~clk_i;

    // Count hit pulses and bullet launches once per cycle, after the edge settles
    always @(posedge clk_i) begin
        #1;
        if (bus.hit_player_o) hitCount++;
        if (bus.pbullet_active_o && !prevActive) launchCount++;
        prevActive = bus.pbullet_active_o;
    end

    // Safety net so a stuck run still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issue nFrames frame ticks, three clocks apart; returns on a falling edge
    task automatic applyStimulus(input int nFrames);
        for (int i = 0; i < nFrames; i++) begin
            @(negedge clk_i); bus.frame_i = 1'b1;
            @(negedge clk_i); bus.frame_i = 1'b0;
            @(negedge clk_i);
        end
    endtask

    task automatic firePulse;
        @(negedge clk_i); bus.fire_btn_i = 1'b1;
        @(negedge clk_i); bus.fire_btn_i = 1'b0;
    endtask

    task automatic clearInputs;
        bus.frame_i          = 1'b0;
        bus.left_btn_i       = 1'b0;
        bus.right_btn_i      = 1'b0;
        bus.fire_btn_i       = 1'b0;
        bus.enemy_hit_i      = 1'b0;
        bus.landed_i         = 1'b0;
        bus.ebullet_active_i = 1'b0;
        bus.ebullet_left_i   = 10'd0;
        bus.ebullet_right_i  = 10'd0;
        bus.ebullet_top_i    = 10'd0;
        bus.ebullet_bot_i    = 10'd0;
    endtask

    task automatic doReset;
        @(negedge clk_i);
        reset_ni = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic setEnemyBullet(input logic [9:0] l, input logic [9:0] r,
                                  input logic [9:0] t, input logic [9:0] b,
                                  input logic act);
        bus.ebullet_left_i   = l;
        bus.ebullet_right_i  = r;
        bus.ebullet_top_i    = t;
        bus.ebullet_bot_i    = b;
        bus.ebullet_active_i = act;
    endtask

    initial begin
        reset_ni = 1'b0;
        clearInputs();
        doReset();

        // Reset state
        checkOutput("rstLeft", bus.left_pos_o, 300);
        checkOutput("rstRight", bus.right_pos_o, 340);
        checkOutput("rstTop", bus.top_pos_o, 440);
        checkOutput("rstBot", bus.bot_pos_o, 460);
        checkOutput("rstPActive", bus.pbullet_active_o, 0);
        checkOutput("rstPTop", bus.pbullet_top_o, 0);
        checkOutput("rstLives", bus.lives_o, 3);
        checkOutput("rstDead", bus.player_dead_o, 0);
        checkOutput("rstHit", bus.hit_player_o, 0);
        checkOutput("rstGreen", bus.player_green_o, 15);
        checkOutput("rstRed", bus.player_red_o, 0);

        // Movement and screen clamps
        bus.right_btn_i = 1'b1;
        maxRight = 0;
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1);
            if (i == 0) checkOutput("firstStep", bus.left_pos_o, 305);
            if (int'(bus.right_pos_o) > maxRight) maxRight = int'(bus.right_pos_o);
        end
        checkOutput("clampRightLeft", bus.left_pos_o, 589);
        checkOutput("clampRightRight", bus.right_pos_o, 629);
        checkOutput("maxRight", maxRight, 629);
        bus.right_btn_i = 1'b0;
        bus.left_btn_i  = 1'b1;
        applyStimulus(130);
        checkOutput("clampLeft", bus.left_pos_o, 9);
        bus.right_btn_i = 1'b1;
        applyStimulus(2);
        checkOutput("bothHold", bus.left_pos_o, 9);
        bus.left_btn_i  = 1'b0;
        bus.right_btn_i = 1'b0;
        applyStimulus(1);
        checkOutput("noneHold", bus.left_pos_o, 9);

        // Launch geometry and flight
        doReset();
        firePulse();
        applyStimulus(1);
        checkOutput("launchActive", bus.pbullet_active_o, 1);
        checkOutput("launchLeft", bus.pbullet_left_o, 319);
        checkOutput("launchRight", bus.pbullet_right_o, 321);
        checkOutput("launchTop", bus.pbullet_top_o, 429);
        checkOutput("launchBot", bus.pbullet_bot_o, 439);
        applyStimulus(5);
        checkOutput("fly5Top", bus.pbullet_top_o, 379);
        checkOutput("fly5Bot", bus.pbullet_bot_o, 389);
        applyStimulus(35);
        checkOutput("fly40Top", bus.pbullet_top_o, 29);
        applyStimulus(1);
        checkOutput("lastTop", bus.pbullet_top_o, 19);
        checkOutput("lastActive", bus.pbullet_active_o, 1);
        applyStimulus(1);
        checkOutput("retireActive", bus.pbullet_active_o, 0);
        checkOutput("retireTop", bus.pbullet_top_o, 0);

        // Enemy hit beats frame; fire during flight is dropped; held fire launches once
        doReset();
        firePulse();
        applyStimulus(2);
        checkOutput("preHitTop", bus.pbullet_top_o, 419);
        firePulse();
        @(negedge clk_i); bus.frame_i = 1'b1; bus.enemy_hit_i = 1'b1;
        @(negedge clk_i); bus.frame_i = 1'b0; bus.enemy_hit_i = 1'b0;
        checkOutput("hitActive", bus.pbullet_active_o, 0);
        checkOutput("hitTop", bus.pbullet_top_o, 0);
        checkOutput("hitLeft", bus.pbullet_left_o, 0);
        checkOutput("hitBot", bus.pbullet_bot_o, 0);
        applyStimulus(1);
        checkOutput("droppedFire", bus.pbullet_active_o, 0);
        base = launchCount;
        @(negedge clk_i); bus.fire_btn_i = 1'b1;
        applyStimulus(50);
        bus.fire_btn_i = 1'b0;
        checkOutput("heldFireLaunches", launchCount - base, 1);
        checkOutput("heldFireActive", bus.pbullet_active_o, 0);

        // Collision, invulnerability window and blink
        doReset();
        base = hitCount;
        setEnemyBullet(10'd310, 10'd312, 10'd445, 10'd455, 1'b1);
        applyStimulus(1);
        checkOutput("hit1Count", hitCount - base, 1);
        checkOutput("hit1Lives", bus.lives_o, 2);
        checkOutput("blinkOff", bus.player_green_o, 0);
        applyStimulus(119);
        checkOutput("invulnCount", hitCount - base, 1);
        checkOutput("invulnLives", bus.lives_o, 2);
        checkOutput("blinkOn", bus.player_green_o, 15);
        applyStimulus(1);
        checkOutput("frame120Count", hitCount - base, 1);
        applyStimulus(1);
        checkOutput("rehitCount", hitCount - base, 2);
        checkOutput("rehitLives", bus.lives_o, 1);

        // Inclusive edges, inactive enemy bullet, three hits to game over
        doReset();
        base = hitCount;
        setEnemyBullet(10'd341, 10'd343, 10'd460, 10'd470, 1'b1);
        applyStimulus(1);
        checkOutput("missCount", hitCount - base, 0);
        setEnemyBullet(10'd340, 10'd342, 10'd460, 10'd470, 1'b0);
        applyStimulus(1);
        checkOutput("inactiveCount", hitCount - base, 0);
        bus.ebullet_active_i = 1'b1;
        applyStimulus(1);
        checkOutput("cornerCount", hitCount - base, 1);
        checkOutput("cornerLives", bus.lives_o, 2);
        applyStimulus(121);
        checkOutput("hit2Lives", bus.lives_o, 1);
        applyStimulus(121);
        checkOutput("hit3Lives", bus.lives_o, 0);
        checkOutput("hit3Dead", bus.player_dead_o, 1);
        checkOutput("hit3Count", hitCount - base, 3);
        bus.ebullet_active_i = 1'b0;
        bus.right_btn_i = 1'b1;
        applyStimulus(5);
        bus.right_btn_i = 1'b0;
        checkOutput("deadFrozen", bus.left_pos_o, 300);
        firePulse();
        applyStimulus(2);
        checkOutput("deadNoFire", bus.pbullet_active_o, 0);
        checkOutput("deadStill", bus.player_dead_o, 1);

        // Landed during invulnerability
        doReset();
        setEnemyBullet(10'd310, 10'd312, 10'd445, 10'd455, 1'b1);
        applyStimulus(1);
        bus.ebullet_active_i = 1'b0;
        applyStimulus(10);
        checkOutput("preLandLives", bus.lives_o, 2);
        @(negedge clk_i); bus.landed_i = 1'b1;
        @(negedge clk_i); bus.landed_i = 1'b0;
        checkOutput("landLives", bus.lives_o, 0);
        checkOutput("landDead", bus.player_dead_o, 1);

        // Asynchronous reset in mid-flight
        doReset();
        bus.right_btn_i = 1'b1;
        applyStimulus(3);
        bus.right_btn_i = 1'b0;
        checkOutput("movedLeft", bus.left_pos_o, 315);
        firePulse();
        applyStimulus(2);
        checkOutput("midFlightTop", bus.pbullet_top_o, 419);
        checkOutput("midFlightLeft", bus.pbullet_left_o, 334);
        @(negedge clk_i);
        reset_ni = 1'b0;
        #1;
        checkOutput("asyncLeft", bus.left_pos_o, 300);
        checkOutput("asyncActive", bus.pbullet_active_o, 0);
        checkOutput("asyncPTop", bus.pbullet_top_o, 0);
        checkOutput("asyncPLeft", bus.pbullet_left_o, 0);
        checkOutput("asyncLives", bus.lives_o, 3);
        checkOutput("asyncDead", bus.player_dead_o, 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
